deint_sched: RTL and testbench
==============================

Name: deint_sched

Overview:
- Per-packet scheduler for the OFDM deinterleaver in the legacy (non-HT) receive path.
- Gates demodulated-carrier strobes into the deinterleaver and drives its rate byte: BPSK-1/2 during SIGNAL, the decoded rate during DATA.
- Pulses the deinterleaver RAM clear at packet start.
- Counts data symbols against the L-SIG length and reports done or abort once the last symbol has fully drained out of the deinterleaver.

Parameters:
- SIG_TIMEOUT, 4096, max cycles in SIG_WAIT before abort.
- DRAIN_TIMEOUT, 1024, max cycles in DRAIN before abort.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- enable  in  1  clock enable; all state frozen when low
- pkt_start  in  1  pulse from sync: new packet begins
- demod_strobe  in  1  one carrier's demapped bits valid upstream
- sig_done  in  1  pulse: SIGNAL field decoded
- sig_ok  in  1  parity/reserved check passed (sampled with sig_done)
- sig_rate  in  4  L-SIG rate code (sampled with sig_done)
- sig_len  in  12  L-SIG length in bytes (sampled with sig_done)
- deint_out_strobe  in  1  deinterleaver output strobe (one bit pair)
- deint_rate  out  8  rate byte to deinterleaver; bit7=0 always
- deint_in_strobe  out  1  gated demod_strobe to deinterleaver
- deint_clr  out  1  one-cycle clear pulse to deinterleaver RAM
- sym_count  out  16  DATA symbols accepted this packet
- busy  out  1  high in any state except IDLE
- pkt_done  out  1  one-cycle pulse, normal completion
- pkt_abort  out  1  one-cycle pulse, abort

Behaviour:
- Reset values:
  - state=IDLE, deint_rate=8'h0B.
  - deint_in_strobe, deint_clr, pkt_done, pkt_abort, busy all 0.
  - sym_count=0; all internal counters 0.
- deint_in_strobe = demod_strobe & enable & (state==SIG_SYM | state==DATA). It is combinational and has zero latency.
- All other outputs are registered.

States:
- IDLE:
  - deint_rate=8'h0B.
  - On pkt_start: deint_clr=1 for one cycle; clear carrier count, sym_count, acc_bits, exp_out and out_cnt; go to SIG_SYM.
- SIG_SYM:
  - Count gated carriers.
  - The strobe that brings the count to 48 is still passed; then go to SIG_WAIT.
- SIG_WAIT:
  - Strobes are dropped.
  - On sig_done:
    - Abort if sig_ok=0, sig_rate[3]=0, or sig_len=0.
    - Otherwise latch deint_rate={4'h0,sig_rate}, set target=22+8*sig_len (16-bit), and go to DATA.
  - Abort if SIG_TIMEOUT cycles elapse without sig_done.
- DATA:
  - Count gated carriers 0..47, wrapping to 0 on the 48th.
  - On each 48th carrier:
    - sym_count+=1
    - acc_bits+=N_DBPS(rate)
    - exp_out+=24*N_BPSC(rate)
  - If the updated acc_bits>=target, go to DRAIN in the same cycle.
  - Gated strobes after that symbol are blocked.
- Output counting: out_cnt counts deint_out_strobe from DATA entry through DRAIN.
- DRAIN:
  - When out_cnt==exp_out: pkt_done pulse, go to IDLE.
  - Abort on DRAIN_TIMEOUT.
  - out_cnt>exp_out is a fault and causes an abort.
- Abort:
  - pkt_abort pulse; go to IDLE.
  - deint_rate returns to 8'h0B on the following cycle.

Boundary conditions:
- pkt_start in any non-IDLE state: pkt_abort and deint_clr pulse in the same cycle, counters clear, go to SIG_SYM.
- pkt_start in IDLE gives no abort.
- sig_done outside SIG_WAIT is ignored.
- A strobe and a sig_done in the same cycle in SIG_WAIT: the strobe is dropped.
- pkt_start and demod_strobe in the same cycle: the strobe is not gated.
- sym_count saturates at 16'hFFFF.
- Reset mid-packet returns to IDLE immediately, with no pulses.

Decomposition:
- Package deint_pkg holds:
  - the state enum;
  - RATE_SIGNAL=8'h0B;
  - N_DATA_CARRIER=48;
  - function n_dbps(rate[3:0]):
    - 0xB→24, 0xF→36, 0xA→48, 0xE→72
    - 0x9→96, 0xD→144, 0x8→192, 0xC→216
    - invalid→0
  - function n_bpsc(rate[3:0]): 1,1,2,2,4,4,6,6 in the same order.
- Sub-module deint_sym_counter holds the carrier-wrap counter plus acc_bits/exp_out accumulators. It emits a sym_end pulse and a last_sym flag.

Test Plan:
- 6 Mbps, len=1 (target 30) → 48 gated SIGNAL strobes, then 2 DATA symbols (96 strobes). sym_count=2, exp_out=48; pkt_done exactly one cycle after the 48th deint_out_strobe.
- 54 Mbps (0xC), len=100 (target 822) → 4 symbols (acc=864), exp_out=576, deint_rate=8'h0C during DATA. A 5th symbol's strobes give deint_in_strobe=0.
- sig_ok=0 at sig_done → pkt_abort pulse, back to IDLE, deint_rate=8'h0B; further demod strobes are not gated.
- No sig_done for SIG_TIMEOUT cycles → pkt_abort exactly at timeout; busy falls next cycle.
- pkt_start mid-DATA (sym_count=3) → pkt_abort and deint_clr in the same cycle; sym_count=0; next 48 strobes counted as SIGNAL.
- enable low for 10 cycles mid-DATA with demod_strobe toggling → counters unchanged, deint_in_strobe=0 throughout.

Source files
------------

// File: rtl/deint_pkg.sv
// Shared types, constants and rate tables for the deinterleaver scheduler.
package deint_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SIG_SYM,
        SIG_WAIT,
        DATA,
        DRAIN
    } state_t;

    localparam logic [7:0]  RATE_SIGNAL    = 8'h0B;
    localparam int unsigned N_DATA_CARRIER = 48;

    // Data bits per OFDM symbol for a legacy rate code; invalid codes give 0.
    function automatic logic [7:0] n_dbps(input logic [3:0] rate);
        case (rate)
            4'hB:    n_dbps = 8'd24;
            4'hF:    n_dbps = 8'd36;
            4'hA:    n_dbps = 8'd48;
            4'hE:    n_dbps = 8'd72;
            4'h9:    n_dbps = 8'd96;
            4'hD:    n_dbps = 8'd144;
            4'h8:    n_dbps = 8'd192;
            4'hC:    n_dbps = 8'd216;
            default: n_dbps = 8'd0;
        endcase
    endfunction

    // Coded bits per subcarrier for a legacy rate code; invalid codes give 0.
    function automatic logic [2:0] n_bpsc(input logic [3:0] rate);
        case (rate)
            4'hB, 4'hF: n_bpsc = 3'd1;
            4'hA, 4'hE: n_bpsc = 3'd2;
            4'h9, 4'hD: n_bpsc = 3'd4;
            4'h8, 4'hC: n_bpsc = 3'd6;
            default:    n_bpsc = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/deint_sched_if.sv
// Link between the scheduler (master) and the deinterleaver (slave).
interface deint_sched_if;

    logic [7:0] deint_rate;
    logic       deint_in_strobe;
    logic       deint_clr;
    logic       deint_out_strobe;

    modport master (
        output deint_rate,
        output deint_in_strobe,
        output deint_clr,
        input  deint_out_strobe
    );

    modport slave (
        input  deint_rate,
        input  deint_in_strobe,
        input  deint_clr,
        output deint_out_strobe
    );

endinterface

// File: rtl/deint_sym_counter.sv
// Carrier-wrap counter with per-packet bit and expected-output accumulators.
module deint_sym_counter
    import deint_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    input  logic        carrier,
    input  logic        data_mode,
    input  logic [3:0]  rate,
    input  logic [15:0] target,
    output logic        wrap,
    output logic        sym_end,
    output logic        last_sym,
    output logic [15:0] exp_out
);

    logic [5:0]  carrier_cnt;
    logic [15:0] acc_bits;
    logic [15:0] acc_next;

    assign wrap     = carrier && (carrier_cnt == 6'(N_DATA_CARRIER - 1));
    assign sym_end  = wrap && data_mode;
    assign acc_next = acc_bits + {8'h00, n_dbps(rate)};
    assign last_sym = sym_end && (acc_next >= target);

    // Carrier position and accumulators; accumulators only advance on DATA symbols.
    always_ff @(posedge clock) begin
        if (reset) begin
            carrier_cnt <= '0;
            acc_bits    <= '0;
            exp_out     <= '0;
        end else if (enable) begin
            if (clear) begin
                carrier_cnt <= '0;
                acc_bits    <= '0;
                exp_out     <= '0;
            end else begin
                if (carrier) begin
                    carrier_cnt <= wrap ? '0 : carrier_cnt + 6'd1;
                end
                if (sym_end) begin
                    acc_bits <= acc_next;
                    exp_out  <= exp_out + 16'd24 * {13'h0000, n_bpsc(rate)};
                end
            end
        end
    end

endmodule

// File: rtl/deint_sched.sv
// Per-packet scheduler for the legacy OFDM deinterleaver.
module deint_sched
    import deint_pkg::*;
#(
    parameter int unsigned SIG_TIMEOUT   = 4096,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 pkt_start,
    input  logic                 demod_strobe,
    input  logic                 sig_done,
    input  logic                 sig_ok,
    input  logic [3:0]           sig_rate,
    input  logic [11:0]          sig_len,
    deint_sched_if.master        deint,
    output logic [15:0]          sym_count,
    output logic                 busy,
    output logic                 pkt_done,
    output logic                 pkt_abort
);

    state_t      state;
    state_t      state_next;
    logic        clr_next;
    logic        done_next;
    logic        abort_next;
    logic        clear_cnt;
    logic        carrier;
    logic        wrap;
    logic        sym_end;
    logic        last_sym;
    logic [15:0] exp_out;
    logic [15:0] target;
    logic [15:0] out_cnt;
    logic [15:0] out_next;
    logic [15:0] timer;
    logic        sig_bad;

    // A strobe coinciding with pkt_start belongs to no packet, so it is never passed.
    assign carrier  = demod_strobe && enable && !pkt_start &&
                      ((state == SIG_SYM) || (state == DATA));
    assign deint.deint_in_strobe = carrier;

    // Completion is judged on the count including this cycle's strobe so
    // pkt_done lands on the cycle right after the final output pair.
    assign out_next = out_cnt + {15'h0000, deint.deint_out_strobe};
    assign sig_bad  = !sig_ok || !sig_rate[3] || (sig_len == 12'd0);

    deint_sym_counter u_sym_counter (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .clear     (clear_cnt),
        .carrier   (carrier),
        .data_mode (state == DATA),
        .rate      (deint.deint_rate[3:0]),
        .target    (target),
        .wrap      (wrap),
        .sym_end   (sym_end),
        .last_sym  (last_sym),
        .exp_out   (exp_out)
    );

    // Next-state and pulse decisions; pkt_start overrides everything.
    always_comb begin
        state_next = state;
        clr_next   = 1'b0;
        done_next  = 1'b0;
        abort_next = 1'b0;
        clear_cnt  = 1'b0;
        if (pkt_start) begin
            state_next = SIG_SYM;
            clr_next   = 1'b1;
            clear_cnt  = 1'b1;
            abort_next = (state != IDLE);
        end else begin
            case (state)
                IDLE: ;
                SIG_SYM: begin
                    if (wrap) state_next = SIG_WAIT;
                end
                SIG_WAIT: begin
                    if (sig_done) begin
                        if (sig_bad) begin
                            abort_next = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = DATA;
                        end
                    end else if (timer == 16'(SIG_TIMEOUT - 1)) begin
                        abort_next = 1'b1;
                        state_next = IDLE;
                    end
                end
                DATA: begin
                    if (last_sym) state_next = DRAIN;
                end
                DRAIN: begin
                    if (out_next == exp_out) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end else if ((out_next > exp_out) ||
                                 (timer == 16'(DRAIN_TIMEOUT - 1))) begin
                        abort_next = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // State, registered outputs, rate/target latch and packet counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            deint.deint_rate <= RATE_SIGNAL;
            deint.deint_clr  <= 1'b0;
            pkt_done         <= 1'b0;
            pkt_abort        <= 1'b0;
            busy             <= 1'b0;
            sym_count        <= '0;
            target           <= '0;
            out_cnt          <= '0;
            timer            <= '0;
        end else if (enable) begin
            state           <= state_next;
            deint.deint_clr <= clr_next;
            pkt_done        <= done_next;
            pkt_abort       <= abort_next;
            busy            <= (state_next != IDLE);

            if ((state_next != state) || !((state == SIG_WAIT) || (state == DRAIN)))
                timer <= '0;
            else
                timer <= timer + 16'd1;

            if (clear_cnt || (state == IDLE)) begin
                deint.deint_rate <= RATE_SIGNAL;
            end else if ((state == SIG_WAIT) && (state_next == DATA)) begin
                deint.deint_rate <= {4'h0, sig_rate};
                target           <= 16'd22 + {1'b0, sig_len, 3'b000};
            end

            if (clear_cnt)
                sym_count <= '0;
            else if (sym_end && (sym_count != '1))
                sym_count <= sym_count + 16'd1;

            if (clear_cnt)
                out_cnt <= '0;
            else if ((state == DATA) || (state == DRAIN))
                out_cnt <= out_next;
        end
    end

endmodule

// File: tb/tb_deint_sched.sv
// Scoreboard bench for deint_sched: packet outcomes queued at stimulus, checked on pulses.
module tb_deint_sched;

    localparam int unsigned SIG_TO   = 300;
    localparam int unsigned DRAIN_TO = 1024;

    typedef struct {
        bit          done;
        logic [15:0] syms;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        pkt_start = 1'b0;
    logic        demod_strobe = 1'b0;
    logic        sig_done = 1'b0;
    logic        sig_ok = 1'b0;
    logic [3:0]  sig_rate = 4'h0;
    logic [11:0] sig_len = 12'h000;
    logic [15:0] sym_count;
    logic        busy;
    logic        pkt_done;
    logic        pkt_abort;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t mon_e;
    int   g;
    int   k;

    deint_sched_if dif ();

    deint_sched #(
        .SIG_TIMEOUT   (SIG_TO),
        .DRAIN_TIMEOUT (DRAIN_TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable       (enable),
        .pkt_start    (pkt_start),
        .demod_strobe (demod_strobe),
        .sig_done     (sig_done),
        .sig_ok       (sig_ok),
        .sig_rate     (sig_rate),
        .sig_len      (sig_len),
        .deint        (dif.master),
        .sym_count    (sym_count),
        .busy         (busy),
        .pkt_done     (pkt_done),
        .pkt_abort    (pkt_abort)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic strobes(input int n, output int gated);
        gated = 0;
        for (int i = 0; i < n; i++) begin
            demod_strobe = 1'b1;
            #1;
            if (dif.deint_in_strobe) gated++;
            step();
        end
        demod_strobe = 1'b0;
    endtask

    task automatic outs(input int n);
        dif.deint_out_strobe = 1'b1;
        for (int i = 0; i < n; i++) step();
        dif.deint_out_strobe = 1'b0;
    endtask

    task automatic start_pkt();
        pkt_start = 1'b1;
        step();
        pkt_start = 1'b0;
    endtask

    task automatic send_sig(input logic ok, input logic [3:0] rate, input logic [11:0] len);
        sig_done = 1'b1;
        sig_ok   = ok;
        sig_rate = rate;
        sig_len  = len;
        step();
        sig_done = 1'b0;
        sig_ok   = 1'b0;
    endtask

    task automatic push_exp(input bit done, input logic [15:0] syms);
        exp_t e;
        e.done = done;
        e.syms = syms;
        sb.push_back(e);
    endtask

    // Every done/abort pulse consumes one queued expectation.
    always @(negedge clock) begin
        if (!reset && (pkt_done || pkt_abort)) begin
            check_eq("sb_has_entry", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check_eq("pkt_outcome", {30'b0, pkt_done, pkt_abort},
                         {30'b0, mon_e.done, !mon_e.done});
                check_eq("pkt_syms", {16'b0, sym_count}, {16'b0, mon_e.syms});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "bench stalled");
    end

    initial begin
        dif.deint_out_strobe = 1'b0;
        repeat (3) step();
        demod_strobe = 1'b1;
        #1;
        check_eq("rst_vals", {dif.deint_rate, 3'b0, dif.deint_clr, busy, pkt_done, pkt_abort,
                              dif.deint_in_strobe, sym_count},
                 {8'h0B, 24'h000000});
        demod_strobe = 1'b0;
        reset = 1'b0;
        step();

        // 6 Mbps, len 1: two symbols, 48 output pairs
        start_pkt();
        check_eq("t1_clr_busy", {30'b0, dif.deint_clr, busy}, 32'd3);
        check_eq("t1_no_abort", {31'b0, pkt_abort}, 32'd0);
        strobes(48, g);
        check_eq("t1_sig_gated", 32'(g), 32'd48);
        strobes(1, g);
        check_eq("t1_sigwait_drop", 32'(g), 32'd0);
        push_exp(1'b1, 16'd2);
        send_sig(1'b1, 4'hB, 12'd1);
        strobes(96, g);
        check_eq("t1_data_gated", 32'(g), 32'd96);
        check_eq("t1_syms", {16'b0, sym_count}, 32'd2);
        strobes(1, g);
        check_eq("t1_drain_drop", 32'(g), 32'd0);
        outs(47);
        check_eq("t1_done_early", {31'b0, pkt_done}, 32'd0);
        outs(1);
        check_eq("t1_done", {31'b0, pkt_done}, 32'd1);
        step();
        check_eq("t1_idle", {23'b0, busy, dif.deint_rate}, 32'h0B);

        // 54 Mbps, len 100: four symbols, 576 output pairs
        start_pkt();
        strobes(48, g);
        send_sig(1'b1, 4'hC, 12'd100);
        check_eq("t2_rate", {24'b0, dif.deint_rate}, 32'h0C);
        strobes(192, g);
        check_eq("t2_data_gated", 32'(g), 32'd192);
        check_eq("t2_syms", {16'b0, sym_count}, 32'd4);
        strobes(48, g);
        check_eq("t2_fifth_blocked", 32'(g), 32'd0);
        push_exp(1'b1, 16'd4);
        outs(575);
        check_eq("t2_done_early", {31'b0, pkt_done}, 32'd0);
        outs(1);
        check_eq("t2_done", {31'b0, pkt_done}, 32'd1);
        step();

        // Bad SIGNAL parity aborts
        start_pkt();
        strobes(48, g);
        push_exp(1'b0, 16'd0);
        send_sig(1'b0, 4'hB, 12'd10);
        check_eq("t3_abort", {30'b0, pkt_abort, busy}, 32'd2);
        step();
        check_eq("t3_rate", {24'b0, dif.deint_rate}, 32'h0B);
        strobes(5, g);
        check_eq("t3_idle_drop", 32'(g), 32'd0);

        // SIGNAL decode timeout
        start_pkt();
        strobes(48, g);
        push_exp(1'b0, 16'd0);
        k = 0;
        while (k < int'(SIG_TO) + 8) begin
            step();
            k++;
            if (k == int'(SIG_TO) - 1) check_eq("t4_busy_before", {31'b0, busy}, 32'd1);
            if (pkt_abort) break;
        end
        check_eq("t4_timeout_cycle", 32'(k), 32'(SIG_TO));
        check_eq("t4_busy_after", {31'b0, busy}, 32'd0);
        step();

        // pkt_start mid-DATA restarts the packet
        start_pkt();
        strobes(48, g);
        send_sig(1'b1, 4'hC, 12'd100);
        strobes(144, g);
        check_eq("t5_syms3", {16'b0, sym_count}, 32'd3);
        push_exp(1'b0, 16'd0);
        pkt_start    = 1'b1;
        demod_strobe = 1'b1;
        #1;
        check_eq("t5_start_strobe", {31'b0, dif.deint_in_strobe}, 32'd0);
        step();
        pkt_start    = 1'b0;
        demod_strobe = 1'b0;
        check_eq("t5_restart", {13'b0, pkt_abort, dif.deint_clr, busy, sym_count}, 32'h70000);
        strobes(48, g);
        check_eq("t5_sig_gated", 32'(g), 32'd48);
        strobes(1, g);
        check_eq("t5_sigwait_drop", 32'(g), 32'd0);
        push_exp(1'b0, 16'd0);
        send_sig(1'b1, 4'h3, 12'd5);
        step();

        // enable low freezes everything mid-DATA
        start_pkt();
        strobes(48, g);
        send_sig(1'b1, 4'hC, 12'd100);
        strobes(100, g);
        check_eq("t6_syms2", {16'b0, sym_count}, 32'd2);
        enable = 1'b0;
        g = 0;
        for (int i = 0; i < 10; i++) begin
            demod_strobe         = (i % 2 == 0);
            dif.deint_out_strobe = (i % 2 == 0);
            #1;
            if (dif.deint_in_strobe) g++;
            step();
        end
        demod_strobe         = 1'b0;
        dif.deint_out_strobe = 1'b0;
        enable = 1'b1;
        check_eq("t6_frozen_gate", 32'(g), 32'd0);
        check_eq("t6_frozen_syms", {16'b0, sym_count}, 32'd2);
        strobes(44, g);
        check_eq("t6_resume_sym3", {16'b0, sym_count}, 32'd3);
        strobes(48, g);
        check_eq("t6_syms4", {16'b0, sym_count}, 32'd4);
        push_exp(1'b1, 16'd4);
        outs(575);
        check_eq("t6_done_early", {31'b0, pkt_done}, 32'd0);
        outs(1);
        check_eq("t6_done", {31'b0, pkt_done}, 32'd1);
        repeat (3) step();

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
